// File: rtl/sc_stream_decoder_pkg.sv
// rtl/sc_stream_decoder_pkg.sv - shared FSM encodings for stochastic stream decoders
//
// Purpose: state encodings shared by SC stream controllers. The encodings are fixed so
//          that other stream controllers and debug tooling decode the state identically.
// Ports:   none (package)

package sc_stream_decoder_pkg;

  typedef enum logic [1:0] {
    SC_DEC_IDLE  = 2'd0,
    SC_DEC_COUNT = 2'd1,
    SC_DEC_HOLD  = 2'd2
  } sc_dec_state_t;

endpackage

// File: rtl/sc_stream_decoder_window_counter.sv
// rtl/sc_stream_decoder_window_counter.sv - saturating sample-window counter
//
// Purpose: counts enabled samples within a window of 2**LEN_W slots. It is used for window
//          framing, and stochastic number generators can reuse it for the same purpose.
// Ports:
//   clk       in   1      clock
//   rst       in   1      synchronous reset, active-high
//   clear     in   1      restart the window (count <= 0)
//   enable    in   1      one sample consumed this cycle
//   count     out  LEN_W  index of the next sample slot
//   terminal  out  1      count is at the last slot (all ones)

module sc_window_counter
  import sc_stream_decoder_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [LEN_W-1:0] count,
  output logic             terminal
);

  assign terminal = &count;

  // Holds at the terminal slot instead of wrapping, so a late enable cannot alias
  // into the next window before it is explicitly cleared.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + LEN_W'(1);
    end
  end

endmodule

// File: rtl/sc_stream_decoder.sv
// rtl/sc_stream_decoder.sv - stochastic bitstream to binary count decoder
//
// Purpose: counts the ones among 2**LEN_W valid samples of a stochastic bitstream and
//          presents the count through a valid/ready output register.
// Ports:
//   clk        in   1      clock
//   rst        in   1      synchronous reset, active-high
//   start      in   1      pulse: begin a new conversion window
//   bit_in     in   1      stochastic bitstream sample
//   bit_valid  in   1      bit_in is a sample this cycle
//   busy       out  1      window is being accumulated
//   out_count  out  CNT_W  number of ones in the completed window
//   out_valid  out  1      out_count valid, held until accepted
//   out_ready  in   1      consumer accepts out_count

module sc_stream_decoder
  import sc_stream_decoder_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               busy,
  output logic [LEN_W:0]     out_count,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int CNT_W = LEN_W + 1;

  sc_dec_state_t state, state_nxt;

  logic [CNT_W-1:0] ones_cnt;
  logic             win_clear;
  logic             win_terminal;
  logic             sample_take;
  logic             finish;
  // The sample index matters only to framing users; the decoder keys off terminal alone.
  logic [LEN_W-1:0] unused_sample_cnt;

  sc_window_counter #(
    .LEN_W (LEN_W)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .clear    (win_clear),
    .enable   (sample_take),
    .count    (unused_sample_cnt),
    .terminal (win_terminal)
  );

  // Gating on bit_valid keeps stalled (possibly unknown) bit_in values out of the counters.
  assign sample_take = (state == SC_DEC_COUNT) && bit_valid;
  assign finish      = sample_take && win_terminal;
  assign busy        = (state == SC_DEC_COUNT);

  always_comb begin
    state_nxt = state;
    win_clear = 1'b0;
    case (state)
      SC_DEC_IDLE: begin
        if (start) begin
          win_clear = 1'b1;
          state_nxt = SC_DEC_COUNT;
        end
      end
      SC_DEC_COUNT: begin
        if (finish) begin
          state_nxt = SC_DEC_HOLD;
        end
      end
      SC_DEC_HOLD: begin
        // The result is never overwritten before it is accepted; start alone is ignored.
        if (out_ready) begin
          if (start) begin
            win_clear = 1'b1;
            state_nxt = SC_DEC_COUNT;
          end else begin
            state_nxt = SC_DEC_IDLE;
          end
        end
      end
      default: begin
        state_nxt = SC_DEC_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SC_DEC_IDLE;
      ones_cnt  <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
    end else begin
      state <= state_nxt;

      if (win_clear) begin
        ones_cnt <= '0;
      end else if (sample_take) begin
        ones_cnt <= ones_cnt + CNT_W'(bit_in);
      end

      // The final sample folds straight into the result, saving one cycle of latency.
      if (finish) begin
        out_count <= ones_cnt + CNT_W'(bit_in);
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
